// File: rtl/score_record_bank_pkg.sv
// ============================================================================
// Module      : score_record_bank_pkg
// Description : Shared constants, FSM encodings and index helper for the
//               learning-mode score record bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_record_bank_pkg;

    localparam int c_SCORE_W    = 32;
    localparam int c_NUM_USERS  = 4;
    localparam int c_NUM_SONGS  = 4;
    localparam int c_NUM_REC    = c_NUM_USERS * c_NUM_SONGS;
    localparam int c_REC_IDX_W  = 4;
    localparam int c_ACC_W      = c_SCORE_W + 2;
    localparam int c_DIV_ITER   = c_ACC_W;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_SUM0 = 3'd1;
    localparam logic [2:0] c_ST_SUM1 = 3'd2;
    localparam logic [2:0] c_ST_SUM2 = 3'd3;
    localparam logic [2:0] c_ST_DIV  = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;

    typedef logic [c_REC_IDX_W-1:0] rec_idx_t;

    function automatic rec_idx_t rec_idx(input logic [1:0] user, input logic [1:0] song);
        return {user, song};
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_record_bank_if.sv
// ============================================================================
// Module      : score_record_bank_if
// Description : Write / read / average request bundle between the learning
//               engine side (master) and the score record bank (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_record_bank_if #(
    parameter int SCORE_W = 32
);
    logic               wr_en;
    logic [1:0]         wr_user;
    logic [1:0]         wr_song;
    logic [SCORE_W-1:0] wr_score;
    logic               wr_ack;
    logic [1:0]         rd_user;
    logic [1:0]         rd_song;
    logic [SCORE_W-1:0] rd_score;
    logic               avg_req;
    logic [SCORE_W-1:0] avg_score;
    logic               avg_valid;
    logic               busy;

    modport master (
        output wr_en, wr_user, wr_song, wr_score, rd_user, rd_song, avg_req,
        input  wr_ack, rd_score, avg_score, avg_valid, busy
    );

    modport slave (
        input  wr_en, wr_user, wr_song, wr_score, rd_user, rd_song, avg_req,
        output wr_ack, rd_score, avg_score, avg_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/score_record_bank_div3_seq.sv
// ============================================================================
// Module      : score_record_bank_div3_seq
// Description : Sequential restoring divide-by-3, one quotient bit per cycle,
//               MSB first. done is high during the final iteration cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_record_bank_div3_seq
    import score_record_bank_pkg::*;
#(
    parameter int WIDTH = c_DIV_ITER
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] dividend,
    output logic      [WIDTH-1:0] quotient,
    output logic                  done
);
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_shift;
    logic [1:0]         r_rem;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_run;

    logic               w_active;
    logic [c_CNT_W-1:0] w_cnt;
    logic [WIDTH-1:0]   w_src;
    logic [1:0]         w_rem;
    logic [2:0]         w_trial;
    logic               w_ge;
    logic [2:0]         w_trial_sub;
    logic [1:0]         w_rem_next;

    // start cycle performs iteration 0 directly on the dividend port
    assign w_active    = start | r_run;
    assign w_cnt       = start ? '0 : r_cnt;
    assign w_src       = start ? dividend : r_shift;
    assign w_rem       = start ? 2'd0 : r_rem;
    assign w_trial     = {w_rem, w_src[WIDTH-1]};
    assign w_ge        = (w_trial >= 3'd3);
    assign w_trial_sub = w_trial - 3'd3;
    assign w_rem_next  = w_ge ? w_trial_sub[1:0] : w_trial[1:0];
    assign done        = w_active && (w_cnt == c_CNT_W'(WIDTH - 1));
    assign quotient    = r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_rem   <= 2'd0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else if (w_active) begin
            r_shift <= {w_src[WIDTH-2:0], w_ge};
            r_rem   <= w_rem_next;
            r_cnt   <= w_cnt + 1'b1;
            r_run   <= !done;
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_record_bank.sv
// ============================================================================
// Module      : score_record_bank
// Description : Per-user/per-song score store with edge-triggered writes,
//               registered write-first read-back and a sequential average.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_record_bank
    import score_record_bank_pkg::*;
#(
    parameter int SCORE_W = c_SCORE_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    score_record_bank_if.slave bus
);
    localparam int c_LOC_ACC_W = SCORE_W + 2;

    logic [SCORE_W-1:0]     r_rec [c_NUM_REC];
    logic                   r_wr_en_q;
    logic                   r_wr_ack;
    logic [SCORE_W-1:0]     r_rd_score;
    logic [2:0]             r_state;
    logic [1:0]             r_user;
    logic [c_LOC_ACC_W-1:0] r_acc;
    logic                   r_dirty;
    logic                   r_div_start;
    logic [SCORE_W-1:0]     r_avg;

    logic                   w_wr_fire;
    rec_idx_t               w_wr_idx;
    rec_idx_t               w_rd_idx;
    logic [1:0]             w_sum_song;
    logic [SCORE_W-1:0]     w_sum_val;
    logic                   w_dirty_hit;
    logic                   w_div_done;
    logic [c_LOC_ACC_W-1:0] w_quo;
    logic                   w_avg_valid;
    logic                   w_unused_quo_msb;

    assign w_wr_fire = bus.wr_en & ~r_wr_en_q;
    assign w_wr_idx  = rec_idx(bus.wr_user, bus.wr_song);
    assign w_rd_idx  = rec_idx(bus.rd_user, bus.rd_song);

    // slot 3 never contributes to the average, so writes to it cannot stale it
    assign w_dirty_hit = w_wr_fire && (r_state != c_ST_IDLE) && (bus.wr_user == r_user)
                         && (bus.wr_song != 2'(c_NUM_SONGS - 1));

    always_comb begin
        w_sum_song = 2'd0;
        case (r_state)
            c_ST_SUM1: w_sum_song = 2'd1;
            c_ST_SUM2: w_sum_song = 2'd2;
            default:   w_sum_song = 2'd0;
        endcase
    end

    assign w_sum_val = r_rec[rec_idx(r_user, w_sum_song)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_REC; i++) r_rec[i] <= '0;
        end else if (w_wr_fire) begin
            r_rec[w_wr_idx] <= bus.wr_score;
        end
    end

    // wr_en_q comes out of reset high so a level already asserted is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en_q  <= 1'b1;
            r_wr_ack   <= 1'b0;
            r_rd_score <= '0;
        end else begin
            r_wr_en_q  <= bus.wr_en;
            r_wr_ack   <= w_wr_fire;
            r_rd_score <= (w_wr_fire && (w_wr_idx == w_rd_idx)) ? bus.wr_score
                                                                 : r_rec[w_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_user      <= 2'd0;
            r_acc       <= '0;
            r_dirty     <= 1'b0;
            r_div_start <= 1'b0;
            r_avg       <= '0;
        end else begin
            r_div_start <= 1'b0;
            if (w_dirty_hit) r_dirty <= 1'b1;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.avg_req) begin
                        r_user  <= bus.rd_user;
                        r_acc   <= '0;
                        r_dirty <= 1'b0;
                        r_state <= c_ST_SUM0;
                    end
                end
                c_ST_SUM0: begin
                    r_acc   <= r_acc + c_LOC_ACC_W'(w_sum_val);
                    r_state <= c_ST_SUM1;
                end
                c_ST_SUM1: begin
                    r_acc   <= r_acc + c_LOC_ACC_W'(w_sum_val);
                    r_state <= c_ST_SUM2;
                end
                c_ST_SUM2: begin
                    r_acc       <= r_acc + c_LOC_ACC_W'(w_sum_val);
                    r_div_start <= 1'b1;
                    r_state     <= c_ST_DIV;
                end
                c_ST_DIV: begin
                    if (w_div_done) r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (r_dirty) begin
                        r_dirty <= 1'b0;
                        r_acc   <= '0;
                        r_state <= c_ST_SUM0;
                    end else begin
                        r_avg   <= w_quo[SCORE_W-1:0];
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    score_record_bank_div3_seq #(
        .WIDTH (c_LOC_ACC_W)
    ) u_div3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (r_div_start),
        .dividend (r_acc),
        .quotient (w_quo),
        .done     (w_div_done)
    );

    // quotient MSBs are provably zero since acc <= 3*(2^SCORE_W - 1)
    assign w_unused_quo_msb = |w_quo[c_LOC_ACC_W-1:SCORE_W];

    assign w_avg_valid   = (r_state == c_ST_DONE) && !r_dirty;
    assign bus.avg_valid = w_avg_valid;
    assign bus.avg_score = w_avg_valid ? w_quo[SCORE_W-1:0] : r_avg;
    assign bus.busy      = (r_state != c_ST_IDLE);
    assign bus.wr_ack    = r_wr_ack;
    assign bus.rd_score  = r_rd_score;

endmodule

`default_nettype wire

// File: tb/tb_score_record_bank.sv
// ============================================================================
// Module      : tb_score_record_bank
// Description : Self-checking bench for score_record_bank against a record
//               array model and arithmetic average reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_record_bank;
    import score_record_bank_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] model_rec [16];

    always #5 clk = ~clk;

    score_record_bank_if #(.SCORE_W(32)) bus ();

    score_record_bank #(.SCORE_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] u, input logic [1:0] s, input logic [31:0] v);
        bus.wr_en    = 1'b1;
        bus.wr_user  = u;
        bus.wr_song  = s;
        bus.wr_score = v;
        model_rec[{u, s}] = v;
        tick();
        chk("wr_ack", bus.wr_ack, 1);
        bus.wr_en = 1'b0;
        tick();
    endtask

    // runs one average request; optional single write and extra avg_req mid-run
    task automatic run_avg(input string tag, input logic [1:0] u, input int wr_cyc,
                           input logic [1:0] wu, input logic [1:0] ws,
                           input logic [31:0] wv, input int req_cyc);
        int          busy_cnt  = 0;
        int          valid_cnt = 0;
        int          valid_cyc = 0;
        logic [31:0] vscore    = '0;
        int          restart;
        logic [33:0] sum;
        logic [31:0] exp_avg;
        restart = (wr_cyc >= 1 && wr_cyc <= 37 && wu == u && ws != 2'd3) ? 1 : 0;
        bus.rd_user = u;
        bus.avg_req = 1'b1;
        tick();
        bus.avg_req = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.busy) busy_cnt++;
            if (bus.avg_valid) begin
                valid_cnt++;
                valid_cyc = c;
                vscore    = bus.avg_score;
            end
            if (!bus.busy) break;
            bus.wr_en = (c == wr_cyc);
            if (c == wr_cyc) begin
                bus.wr_user  = wu;
                bus.wr_song  = ws;
                bus.wr_score = wv;
                model_rec[{wu, ws}] = wv;
            end
            bus.avg_req = (c == req_cyc);
            bus.rd_user = (c == req_cyc) ? ~u : u;
            tick();
        end
        bus.wr_en   = 1'b0;
        bus.avg_req = 1'b0;
        sum = 34'(model_rec[{u, 2'd0}]) + 34'(model_rec[{u, 2'd1}]) + 34'(model_rec[{u, 2'd2}]);
        exp_avg = 32'(sum / 3);
        chk({tag, "_busy_cycles"}, busy_cnt, 38 * (1 + restart));
        chk({tag, "_valid_count"}, valid_cnt, 1);
        chk({tag, "_valid_cycle"}, valid_cyc, 38 * (1 + restart));
        chk({tag, "_avg"}, vscore, exp_avg);
        chk({tag, "_avg_held"}, bus.avg_score, exp_avg);
    endtask

    initial begin
        int ack_cnt;
        logic [1:0] ru, rs;
        for (int i = 0; i < 16; i++) model_rec[i] = '0;
        bus.wr_en = 0; bus.wr_user = 0; bus.wr_song = 0; bus.wr_score = 0;
        bus.rd_user = 0; bus.rd_song = 0; bus.avg_req = 0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_avg_valid", bus.avg_valid, 0);
        chk("rst_wr_ack", bus.wr_ack, 0);
        chk("rst_rd_score", bus.rd_score, 0);
        chk("rst_avg_score", bus.avg_score, 0);
        rst_n = 1'b1;
        tick();

        do_write(2'd1, 2'd0, 32'd90);
        do_write(2'd1, 2'd1, 32'd80);
        do_write(2'd1, 2'd2, 32'd70);
        run_avg("u1_basic", 2'd1, 0, 0, 0, 0, 0);

        do_write(2'd2, 2'd0, 32'd100);
        do_write(2'd2, 2'd1, 32'd100);
        do_write(2'd2, 2'd2, 32'd101);
        run_avg("u2_basic", 2'd2, 0, 0, 0, 0, 0);

        for (int s = 0; s < 4; s++) do_write(2'd3, 2'(s), 32'hFFFF_FFFF);
        run_avg("u3_max", 2'd3, 0, 0, 0, 0, 0);
        do_write(2'd3, 2'd3, 32'd5);
        run_avg("u3_slot3", 2'd3, 0, 0, 0, 0, 0);

        do_write(2'd0, 2'd2, 32'd7);
        bus.wr_en = 1'b1; bus.wr_user = 2'd0; bus.wr_song = 2'd2; bus.wr_score = 32'd42;
        bus.rd_user = 2'd0; bus.rd_song = 2'd2;
        model_rec[2] = 32'd42;
        ack_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.wr_ack) ack_cnt++;
            if (c == 0) chk("bypass_rd", bus.rd_score, 42);
        end
        bus.wr_en = 1'b0;
        tick();
        chk("held_wr_single_ack", ack_cnt, 1);

        run_avg("u1_dirty", 2'd1, 20, 2'd1, 2'd0, 32'd120, 0);
        run_avg("u1_other_user", 2'd1, 20, 2'd2, 2'd0, 32'd55, 0);
        run_avg("u1_req_ignored", 2'd1, 0, 0, 0, 0, 10);

        for (int k = 0; k < 6; k++) begin
            ru = 2'($urandom_range(0, 3));
            for (int s = 0; s < 4; s++) do_write(ru, 2'(s), $urandom);
            run_avg("rand", ru, $urandom_range(0, 40), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), $urandom, 0);
        end
        for (int k = 0; k < 16; k++) begin
            ru = 2'($urandom_range(0, 3));
            rs = 2'($urandom_range(0, 3));
            bus.rd_user = ru; bus.rd_song = rs;
            tick();
            chk("rand_read", bus.rd_score, model_rec[{ru, rs}]);
        end

        bus.rd_user = 2'd1; bus.avg_req = 1'b1;
        tick();
        bus.avg_req = 1'b0;
        repeat (14) tick();
        chk("pre_reset_busy", bus.busy, 1);
        bus.wr_en = 1'b1; bus.wr_user = 2'd1; bus.wr_song = 2'd1; bus.wr_score = 32'd55;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_avg_valid", bus.avg_valid, 0);
        for (int i = 0; i < 16; i++) model_rec[i] = '0;
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        ack_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.wr_ack) ack_cnt++;
        end
        chk("rst_release_no_ack", ack_cnt, 0);
        bus.wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.rd_user = 2'(i >> 2);
            bus.rd_song = 2'(i);
            tick();
            chk("post_rst_read", bus.rd_score, model_rec[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
